feetech_move_scheduler: RTL
===========================

// Module: feetech_move_scheduler
// PURPOSE
//  Shares one Feetech continuous-rotation servo between NREQ requesters (strategy FSM, manual/test).
//  Arbitrates round-robin and runs one timed move per grant: drive, then settle at neutral.
//  Tracks extended/retracted position and refuses redundant moves.
//  Output duty feeds the existing PWM module's duty input; this block owns no PWM pin.
// PARAMETERS
//  NREQ          2            number of requesters (>=2)
//  DUTY_NEUTRAL  75000        duty while stopped (clk cycles of high time)
//  DUTY_FWD      60000        duty while extending (avancer)
//  DUTY_REV      90000        duty while retracting (reculer)
//  MOVE_CYCLES   100000000    drive duration in clk cycles (>=1)
//  SETTLE_CYCLES 5000000      neutral hold after a move before done (>=1)
// PORTS
//  clk        in   1     system clock
//  reset      in   1     asynchronous, active-low reset
//  req_valid  in   NREQ  request pending; held until req_ready seen, dropped next cycle
//  req_dir    in   NREQ  per requester: 1 = extend, 0 = retract; stable while req_valid
//  abort      in   1     stop an in-progress drive phase
//  req_ready  out  NREQ  one-hot 1-cycle pulse: request consumed
//  done       out  NREQ  one-hot 1-cycle pulse: granted move finished (incl. aborted)
//  rejected   out  NREQ  one-hot 1-cycle pulse, coincident with req_ready: move redundant
//  aborted    out  1     1-cycle pulse coincident with done when the move was aborted
//  duty       out  32    duty to PWM module
//  busy       out  1     high in every state except IDLE
//  position   out  1     1 = extended, 0 = retracted
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, duty=DUTY_NEUTRAL, position=0, rr pointer=0,
//   all pulses 0, busy=0, counter=0. Reset mid-move: duty neutral immediately, position forced 0.
//  States: IDLE, MOVE, SETTLE, FINISH.
//  IDLE, cycle T, any req_valid: grant index g = first valid at/after rr pointer (wrapping).
//   Latch g and req_dir[g]. Only the IDLE cycle arbitrates; requests during busy wait.
//  T+1: req_ready[g]=1.
//   If req_dir[g]==position: rejected[g]=1; go to FINISH; duty stays neutral.
//   Else go to MOVE; duty=DUTY_FWD (dir 1) or DUTY_REV (dir 0) from T+1.
//  MOVE: drive duty held exactly MOVE_CYCLES cycles. After the last one:
//   position<=dir, duty=DUTY_NEUTRAL, counter cleared, go to SETTLE.
//  abort in MOVE: next cycle duty neutral, position unchanged, go to SETTLE, set abort flag.
//   abort in IDLE, SETTLE or FINISH is ignored.
//  SETTLE: duty neutral for exactly SETTLE_CYCLES cycles, then go to FINISH.
//  FINISH (1 cycle): done[g]=1; aborted=1 if abort flag set.
//   rr pointer <= (g+1) mod NREQ; go to IDLE.
//   Rejected requests also pass through FINISH, so done[g] follows one cycle after rejected[g].
//  Counter: 32-bit, unsigned, cleared on every state entry, never wraps (params < 2^32).
//  Protocol violation: if valid is still high after ready, it is a new request, served at next IDLE.
//  Duty changes only at state transitions. Output pulses are registered; no combinational paths in->out.
// STRUCTURE
//  feetech_pkg: state enum, DIR_EXTEND/DIR_RETRACT, default duty constants.
//  Sub-module rr_arbiter (NREQ param): req vector + pointer -> one-hot grant + index.
//  The counter and FSM stay in this module.
// TESTING (MOVE_CYCLES=10, SETTLE_CYCLES=4, NREQ=2)
//  Reset released, req_valid=01 dir=1 -> ready[0] at T+1, duty=60000 for 10 cycles,
//   then 75000, done[0] at T+15, position=1.
//  position=1, req 0 dir=1 -> ready[0] and rejected[0] at T+1, done[0] at T+2, duty stays 75000.
//  req_valid=11 in the same cycle -> requester 0 served first, requester 1 served after done[0];
//   repeat both -> order 1 then 0.
//  abort on cycle 5 of MOVE -> duty 75000 next cycle, position unchanged,
//   done and aborted pulse together after 4 settle cycles.
//  reset asserted mid-MOVE -> duty=75000, busy=0, position=0 asynchronously;
//   the next request is served normally.
//  abort pulsed in IDLE and SETTLE -> no effect on timing, aborted stays 0.

Source files
------------

// File: rtl/feetech_move_scheduler_pkg.sv
// Shared types and defaults for the Feetech servo move scheduler.
// Duty values are PWM high-time in clock cycles.
package feetech_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SETTLE,
    ST_FINISH
  } state_e;

  localparam logic DIR_EXTEND  = 1'b1;
  localparam logic DIR_RETRACT = 1'b0;

  localparam logic [31:0] DEF_DUTY_NEUTRAL = 32'd75000;
  localparam logic [31:0] DEF_DUTY_FWD     = 32'd60000;
  localparam logic [31:0] DEF_DUTY_REV     = 32'd90000;

  function automatic logic [31:0] driveDuty(input logic dir,
                                            input logic [31:0] fwd,
                                            input logic [31:0] rev);
    return (dir == DIR_RETRACT) ? rev : fwd;
  endfunction

endpackage

// File: rtl/feetech_move_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first pending request at or after the pointer,
// wrapping around, and reports it both one-hot and as an index.
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  int              sum;
  logic [IDXW-1:0] cand;
  logic            found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = 0;
    cand    = '0;
    for (int off = 0; off < int'(NREQ); off++) begin
      sum = int'(ptr_i) + off;
      if (sum >= int'(NREQ)) sum = sum - int'(NREQ);
      cand = IDXW'(sum);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/feetech_move_scheduler.sv
// Shares one continuous-rotation servo between requesters: round-robin grant,
// one timed drive then a neutral settle per grant, redundant moves refused.
module feetech_move_scheduler
  import feetech_pkg::*;
#(
  parameter int unsigned NREQ          = 2,
  parameter logic [31:0] DUTY_NEUTRAL  = DEF_DUTY_NEUTRAL,
  parameter logic [31:0] DUTY_FWD      = DEF_DUTY_FWD,
  parameter logic [31:0] DUTY_REV      = DEF_DUTY_REV,
  parameter logic [31:0] MOVE_CYCLES   = 32'd100000000,
  parameter logic [31:0] SETTLE_CYCLES = 32'd5000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_dir,
  input  logic            abort,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] rejected,
  output logic            aborted,
  output logic [31:0]     duty,
  output logic            busy,
  output logic            position
);

  localparam int unsigned IDXW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     duty_q, duty_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [NREQ-1:0] rejected_q, rejected_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IDXW-1:0] grantIdx_q, grantIdx_d;
  logic [IDXW-1:0] rrPtr_q, rrPtr_d;
  logic            dir_q, dir_d;
  logic            position_q, position_d;
  logic            aborted_q, aborted_d;
  logic            abortFlag_q, abortFlag_d;
  logic            rejPend_q, rejPend_d;

  logic [NREQ-1:0] arbGrant;
  logic [IDXW-1:0] arbIdx;
  logic            arbValid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (arbGrant),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      duty_q      <= DUTY_NEUTRAL;
      grant_q     <= '0;
      ready_q     <= '0;
      rejected_q  <= '0;
      done_q      <= '0;
      grantIdx_q  <= '0;
      rrPtr_q     <= '0;
      dir_q       <= 1'b0;
      position_q  <= 1'b0;
      aborted_q   <= 1'b0;
      abortFlag_q <= 1'b0;
      rejPend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      duty_q      <= duty_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      rejected_q  <= rejected_d;
      done_q      <= done_d;
      grantIdx_q  <= grantIdx_d;
      rrPtr_q     <= rrPtr_d;
      dir_q       <= dir_d;
      position_q  <= position_d;
      aborted_q   <= aborted_d;
      abortFlag_q <= abortFlag_d;
      rejPend_q   <= rejPend_d;
    end
  end

  // A rejected grant spends two cycles in FINISH so its done pulse trails rejected by one.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    duty_d      = duty_q;
    grant_d     = grant_q;
    grantIdx_d  = grantIdx_q;
    rrPtr_d     = rrPtr_q;
    dir_d       = dir_q;
    position_d  = position_q;
    abortFlag_d = abortFlag_q;
    rejPend_d   = rejPend_q;
    ready_d     = '0;
    rejected_d  = '0;
    done_d      = '0;
    aborted_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arbValid) begin
          grant_d     = arbGrant;
          grantIdx_d  = arbIdx;
          dir_d       = req_dir[arbIdx];
          ready_d     = arbGrant;
          abortFlag_d = 1'b0;
          count_d     = '0;
          if (req_dir[arbIdx] == position_q) begin
            rejected_d = arbGrant;
            rejPend_d  = 1'b1;
            state_d    = ST_FINISH;
          end else begin
            duty_d  = driveDuty(req_dir[arbIdx], DUTY_FWD, DUTY_REV);
            state_d = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        if (abort) begin
          duty_d      = DUTY_NEUTRAL;
          abortFlag_d = 1'b1;
          count_d     = '0;
          state_d     = ST_SETTLE;
        end else if (count_q == MOVE_CYCLES - 32'd1) begin
          duty_d     = DUTY_NEUTRAL;
          position_d = dir_q;
          count_d    = '0;
          state_d    = ST_SETTLE;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      ST_SETTLE: begin
        if (count_q == SETTLE_CYCLES - 32'd1) begin
          done_d    = grant_q;
          aborted_d = abortFlag_q;
          count_d   = '0;
          state_d   = ST_FINISH;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      ST_FINISH: begin
        if (rejPend_q) begin
          rejPend_d = 1'b0;
          done_d    = grant_q;
          aborted_d = abortFlag_q;
        end else begin
          rrPtr_d = (grantIdx_q == IDXW'(NREQ - 1)) ? '0 : grantIdx_q + IDXW'(1);
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = ready_q;
  assign rejected  = rejected_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign duty      = duty_q;
  assign position  = position_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
